mdu_unit: RTL and testbench

- Parametrised multiply/divide unit in the E stage. It owns the HI/LO registers and a latency counter, and drives the busy flag that the stall unit consumes as e_mdu_busy.
- Successor to the fixed-latency MDU: multiply and divide latencies and the data width are parameters.
- Adds a cancel input so an exception or flush can abort an in-flight operation.

---
 rtl/mdu_defs.sv | 37 +++
 rtl/mdu_arith.sv | 72 +++++++
 rtl/mdu_unit.sv | 132 +++++++++++++
 tb/tb_mdu_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_defs.sv
// Shared op encodings, FSM state type and op-class decode helpers for the MDU.
package mdu_defs;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] MDU_NONE = 4'd0;
  localparam logic [OP_W-1:0] MULT     = 4'd1;
  localparam logic [OP_W-1:0] MULTU    = 4'd2;
  localparam logic [OP_W-1:0] DIV      = 4'd3;
  localparam logic [OP_W-1:0] DIVU     = 4'd4;
  localparam logic [OP_W-1:0] MFHI     = 4'd5;
  localparam logic [OP_W-1:0] MFLO     = 4'd6;
  localparam logic [OP_W-1:0] MTHI     = 4'd7;
  localparam logic [OP_W-1:0] MTLO     = 4'd8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mdu_state_e;

  function automatic logic is_mult(input logic [OP_W-1:0] op);
    return (op == MULT) || (op == MULTU);
  endfunction

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic is_start(input logic [OP_W-1:0] op);
    return is_mult(op) || is_div(op);
  endfunction

  function automatic logic is_mt(input logic [OP_W-1:0] op);
    return (op == MTHI) || (op == MTLO);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath: produces the HI/LO pair for a start op
// plus a divide-by-zero flag so the caller can suppress the commit.
module mdu_arith
  import mdu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o,
  output logic             div_by_zero_o
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               div_signed;
  logic               a_neg;
  logic               b_neg;
  logic               b_zero;
  logic               div_ovf;
  logic [WIDTH-1:0]   b_safe;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // Sign-extending to 2*WIDTH makes the truncated unsigned product the signed one.
  assign prod_s = {{WIDTH{a_i[WIDTH-1]}}, a_i} * {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

  assign div_signed = (op_i == DIV);
  assign b_zero     = (b_i == '0);
  assign b_safe     = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_i;
  assign a_neg      = div_signed & a_i[WIDTH-1];
  assign b_neg      = div_signed & b_safe[WIDTH-1];
  assign abs_a      = a_neg ? -a_i : a_i;
  assign abs_b      = b_neg ? -b_safe : b_safe;
  assign q_mag      = abs_a / abs_b;
  assign r_mag      = abs_a % abs_b;
  assign div_ovf    = div_signed && (a_i == MOST_NEG) && (b_i == '1);

  always_comb begin
    quo = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem = a_neg ? -r_mag : r_mag;
    if (div_ovf) begin
      quo = MOST_NEG;
      rem = '0;
    end
  end

  always_comb begin
    res_hi_o      = '0;
    res_lo_o      = '0;
    div_by_zero_o = is_div(op_i) && b_zero;
    case (op_i)
      MULT:      {res_hi_o, res_lo_o} = prod_s;
      MULTU:     {res_hi_o, res_lo_o} = prod_u;
      DIV, DIVU: begin
        res_hi_o = rem;
        res_lo_o = quo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs a latency down-counter and
// raises busy for exactly MULT_CYCLES/DIV_CYCLES cycles per accepted op.
//
// state  | meaning
// S_IDLE | accepts start ops and MTHI/MTLO
// S_BUSY | op in flight; pending result commits when the counter reaches 1
module mdu_unit
  import mdu_defs::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             div_by_zero;

  mdu_arith #(
    .WIDTH(WIDTH)
  ) u_arith (
    .op_i          (op),
    .a_i           (a),
    .b_i           (b),
    .res_hi_o      (res_hi),
    .res_lo_o      (res_lo),
    .div_by_zero_o (div_by_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE: begin
        if (!cancel) begin
          if (is_start(op)) begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            pend_wr_d = !div_by_zero;
            cnt_d     = is_mult(op) ? MULT_LOAD : DIV_LOAD;
            state_d   = S_BUSY;
          end else if (is_mt(op)) begin
            if (op == MTHI) hi_d = a;
            else            lo_d = a;
          end
        end
      end
      S_BUSY: begin
        // New ops are ignored here; the stall unit holds them upstream.
        if (cancel) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_ONE) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q == S_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    rdata = '0;
    if (op == MFHI)      rdata = hi_q;
    else if (op == MFLO) rdata = lo_q;
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: arithmetic reference model checked every cycle,
// plus hand-computed literal expectations and a second short/long latency instance.
module tb_mdu_unit;
  import mdu_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        cancel;
  logic        busy;
  logic [31:0] hi, lo, rdata;

  logic [3:0]  op2;
  logic [31:0] a2, b2;
  logic        cancel2;
  logic        busy2;
  logic [31:0] hi2, lo2, rdata2;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busy), .hi(hi), .lo(lo), .rdata(rdata)
  );

  mdu_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(32)) dut2 (
    .clk(clk), .reset(reset), .op(op2), .a(a2), .b(b2), .cancel(cancel2),
    .busy(busy2), .hi(hi2), .lo(lo2), .rdata(rdata2)
  );

  // Reference model: remaining busy cycles plus a pending result computed with plain arithmetic.
  int          m_rem;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_pwr;

  always @(posedge clk or posedge reset) begin
    longint          sp;
    longint unsigned up;
    int              sq, sr;
    if (reset) begin
      m_rem = 0; m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwr = 0;
    end else if (m_rem > 0) begin
      if (cancel) m_rem = 0;
      else if (m_rem == 1) begin
        if (m_pwr) begin m_hi = m_phi; m_lo = m_plo; end
        m_rem = 0;
      end else m_rem = m_rem - 1;
    end else if (!cancel) begin
      case (op)
        MULT: begin
          sp = longint'($signed(a)) * longint'($signed(b));
          {m_phi, m_plo} = sp; m_pwr = 1; m_rem = 5;
        end
        MULTU: begin
          up = longint'({32'd0, a}) * longint'({32'd0, b});
          {m_phi, m_plo} = up; m_pwr = 1; m_rem = 5;
        end
        DIV: begin
          m_pwr = (b != 0); m_rem = 10;
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m_plo = a; m_phi = 0;
          end else if (b != 0) begin
            sq = $signed(a) / $signed(b);
            sr = $signed(a) % $signed(b);
            m_plo = sq; m_phi = sr;
          end
        end
        DIVU: begin
          m_pwr = (b != 0); m_rem = 10;
          if (b != 0) begin m_plo = a / b; m_phi = a % b; end
        end
        MTHI: m_hi = a;
        MTLO: m_lo = a;
        default: ;
      endcase
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] m_rd;
    if (chk_en && !reset) begin
      m_rd = (op == MFHI) ? m_hi : (op == MFLO) ? m_lo : 32'd0;
      check("model busy", {31'd0, busy}, {31'd0, m_rem > 0});
      check("model hi", hi, m_hi);
      check("model lo", lo, m_lo);
      check("model rdata", rdata, m_rd);
    end
  end

  task automatic drive(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input logic c);
    op = o; a = aa; b = bb; cancel = c;
    @(posedge clk); #1;
    op = MDU_NONE; cancel = 1'b0;
  endtask

  task automatic drive2(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb);
    op2 = o; a2 = aa; b2 = bb;
    @(posedge clk); #1;
    op2 = MDU_NONE;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin n++; drive(MDU_NONE, 0, 0, 0); end
  endtask

  task automatic wait_idle2(output int n);
    n = 0;
    while (busy2 && n < 200) begin n++; drive2(MDU_NONE, 0, 0); end
  endtask

  initial begin
    int n;
    reset = 1'b1; op = MDU_NONE; a = 0; b = 0; cancel = 0;
    op2 = MDU_NONE; a2 = 0; b2 = 0; cancel2 = 0;
    #2;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;

    // signed multiply, busy width and hold-until-commit
    drive(MULT, 32'hFFFF_FFFF, 32'h2, 0);
    check("mult busy rise", {31'd0, busy}, 32'd1);
    check("mult hi held", hi, 32'd0);
    wait_idle(n);
    check("mult width", n, 5);
    check("mult hi", hi, 32'hFFFF_FFFF);
    check("mult lo", lo, 32'hFFFF_FFFE);

    drive(MULTU, 32'hFFFF_FFFF, 32'h2, 0);
    wait_idle(n);
    check("multu width", n, 5);
    check("multu hi", hi, 32'h1);
    check("multu lo", lo, 32'hFFFF_FFFE);

    drive(DIV, 32'hFFFF_FFF9, 32'h2, 0);
    wait_idle(n);
    check("div width", n, 10);
    check("div lo", lo, 32'hFFFF_FFFD);
    check("div hi", hi, 32'hFFFF_FFFF);

    // MTHI/MTLO then divide by zero leaves HI/LO alone
    drive(MTHI, 32'h1234_5678, 0, 0);
    drive(MTLO, 32'h0, 0, 0);
    check("mthi", hi, 32'h1234_5678);
    drive(DIVU, 32'd7, 32'd0, 0);
    wait_idle(n);
    check("divz width", n, 10);
    check("divz hi", hi, 32'h1234_5678);
    check("divz lo", lo, 32'h0);
    op = MFHI; #1;
    check("mfhi rdata", rdata, 32'h1234_5678);
    op = MDU_NONE; #1;
    check("none rdata", rdata, 32'h0);

    drive(DIVU, 32'd100, 32'd7, 0);
    wait_idle(n);
    check("divu lo", lo, 32'd14);
    check("divu hi", hi, 32'd2);

    drive(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    wait_idle(n);
    check("divovf lo", lo, 32'h8000_0000);
    check("divovf hi", hi, 32'h0);

    // cancel in busy cycle 4, then cancel in idle
    drive(DIV, 32'd100, 32'd7, 0);
    drive(MDU_NONE, 0, 0, 0);
    drive(MDU_NONE, 0, 0, 0);
    drive(MDU_NONE, 0, 0, 0);
    drive(MDU_NONE, 0, 0, 1);
    check("cancel busy", {31'd0, busy}, 32'd0);
    check("cancel hi", hi, 32'h0);
    check("cancel lo", lo, 32'h8000_0000);
    drive(MULT, 32'd3, 32'd3, 1);
    check("idle cancel busy", {31'd0, busy}, 32'd0);
    drive(MTHI, 32'hAAAA_5555, 0, 1);
    check("idle cancel mthi", hi, 32'h0);

    // ops presented while busy (including the commit cycle) are dropped
    drive(MULT, 32'd3, 32'd4, 0);
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) drive(MULT, 32'd100, 32'd100, 0);
      else            drive(MTLO, 32'hDEAD, 0, 0);
    end
    check("ignore busy", {31'd0, busy}, 32'd0);
    check("ignore hi", hi, 32'd0);
    check("ignore lo", lo, 32'd12);
    drive(MULT, 32'd5, 32'd6, 0);
    check("accept after", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("accept lo", lo, 32'd30);

    // asynchronous reset mid-divide
    drive(DIV, 32'd100, 32'd7, 0);
    drive(MDU_NONE, 0, 0, 0);
    drive(MDU_NONE, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    check("async busy", {31'd0, busy}, 32'd0);
    check("async hi", hi, 32'd0);
    check("async lo", lo, 32'd30 & 32'd0);
    reset = 1'b0;
    drive(MULT, 32'd2, 32'd3, 0);
    wait_idle(n);
    check("post reset lo", lo, 32'd6);

    // 1-cycle multiply / 32-cycle divide instance
    drive2(MULT, 32'd6, 32'd7);
    wait_idle2(n);
    check("dut2 mult width", n, 1);
    check("dut2 mult lo", lo2, 32'd42);
    drive2(DIV, 32'd100, 32'd7);
    wait_idle2(n);
    check("dut2 div width", n, 32);
    check("dut2 div lo", lo2, 32'd14);
    check("dut2 div hi", hi2, 32'd2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
